// File: rtl/lsu_l1d_req_pkg.sv
// Shared encodings for the L1D load/store requester: access sizes, FSM states
// and the enable/zero constants used by the datapath.
package lsu_l1d_req_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_WAIT  = 2'd1,
    RMW_WAIT = 2'd2,
    RMW_WR   = 2'd3
  } lsu_state_e;

  localparam logic        ON        = 1'b1;
  localparam logic        OFF       = 1'b0;
  localparam logic [31:0] WORD_ZERO = 32'h0;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: misalign detect on the incoming request, load
// lane extract with sign/zero extension, and sub-word store merge.
module lsu_lane_align
  import lsu_l1d_req_pkg::*;
(
  input  logic [1:0]  chk_size,
  input  logic [1:0]  chk_addr,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic        misalign,
  output logic [31:0] ld_data,
  output logic [31:0] st_merge
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (chk_size)
      SZ_B:    misalign = OFF;
      SZ_H:    misalign = chk_addr[0];
      SZ_W:    misalign = |chk_addr;
      default: misalign = ON;
    endcase
  end

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (size)
      SZ_B:    ld_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_H:    ld_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default: ld_data = rdata;
    endcase
  end

  // Only the addressed lane is replaced; the rest of the read word passes through.
  always_comb begin
    st_merge = rdata;
    case (size)
      SZ_B: begin
        case (addr_lo)
          2'd0:    st_merge[7:0]   = wdata[7:0];
          2'd1:    st_merge[15:8]  = wdata[7:0];
          2'd2:    st_merge[23:16] = wdata[7:0];
          default: st_merge[31:24] = wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (addr_lo[1]) st_merge[31:16] = wdata[15:0];
        else            st_merge[15:0]  = wdata[15:0];
      end
      default: st_merge = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_l1d_req.sv
// Load/store requester driving the word-only L1D port; sub-word stores are
// performed as read-modify-write. All outputs are registered.
//
// state    | meaning
// IDLE     | ready for a request; word stores and misaligned replies complete here
// LD_WAIT  | load read issued, waiting for L1D data (may be killed by flush)
// RMW_WAIT | sub-word store read issued, waiting for the word to merge into
// RMW_WR   | merged word being written, store response pulsing
module lsu_l1d_req
  import lsu_l1d_req_pkg::*;
#(
  parameter int TAG_W  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_store_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  input  logic              flush_i,
  output logic              rsp_valid_o,
  output logic [TAG_W-1:0]  rsp_tag_o,
  output logic [31:0]       rsp_data_o,
  output logic              rsp_misalign_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i
);

  lsu_state_e state_q, state_d;

  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [TAG_W-1:0]  tag_q;
  logic              kill_q, kill_d;
  logic              cap_en;

  logic              rsp_valid_d, rsp_mis_d;
  logic [TAG_W-1:0]  rsp_tag_d;
  logic [31:0]       rsp_data_d;
  logic              mem_we_d, mem_re_d;
  logic [ADDR_W-1:0] mem_waddr_d, mem_raddr_d;
  logic [31:0]       mem_wdata_d;

  logic              accept;
  logic              req_misalign;
  logic [31:0]       ld_data;
  logic [31:0]       st_merge;
  logic [ADDR_W-1:0] req_word_addr;
  logic [ADDR_W-1:0] cap_word_addr;

  assign accept        = req_valid_i & req_ready_o;
  assign req_word_addr = {req_addr_i[ADDR_W-1:2], 2'b00};
  assign cap_word_addr = {addr_q[ADDR_W-1:2], 2'b00};

  lsu_lane_align u_align (
    .chk_size    (req_size_i),
    .chk_addr    (req_addr_i[1:0]),
    .size        (size_q),
    .addr_lo     (addr_q[1:0]),
    .is_unsigned (uns_q),
    .rdata       (mem_rdata_i),
    .wdata       (wdata_q),
    .misalign    (req_misalign),
    .ld_data     (ld_data),
    .st_merge    (st_merge)
  );

  always_comb begin
    state_d     = state_q;
    kill_d      = OFF;
    cap_en      = OFF;
    rsp_valid_d = OFF;
    rsp_mis_d   = OFF;
    rsp_tag_d   = '0;
    rsp_data_d  = WORD_ZERO;
    mem_we_d    = OFF;
    mem_re_d    = OFF;
    mem_waddr_d = mem_waddr_o;
    mem_raddr_d = mem_raddr_o;
    mem_wdata_d = mem_wdata_o;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cap_en = ON;
          if (req_misalign) begin
            rsp_valid_d = ON;
            rsp_mis_d   = ON;
            rsp_tag_d   = req_tag_i;
          end else if (req_store_i && req_size_i == SZ_W) begin
            mem_we_d    = ON;
            mem_waddr_d = req_word_addr;
            mem_wdata_d = req_wdata_i;
            rsp_valid_d = ON;
            rsp_tag_d   = req_tag_i;
          end else if (req_store_i) begin
            mem_re_d    = ON;
            mem_raddr_d = req_word_addr;
            state_d     = RMW_WAIT;
          end else begin
            mem_re_d    = ON;
            mem_raddr_d = req_word_addr;
            kill_d      = flush_i;
            state_d     = LD_WAIT;
          end
        end
      end

      // A killed load still drains its read so the L1D return never lands
      // on a later request.
      LD_WAIT: begin
        kill_d = kill_q | flush_i;
        if (mem_rvalid_i) begin
          state_d = IDLE;
          if (!(kill_q | flush_i)) begin
            rsp_valid_d = ON;
            rsp_tag_d   = tag_q;
            rsp_data_d  = ld_data;
          end
        end
      end

      RMW_WAIT: begin
        if (mem_rvalid_i) begin
          mem_we_d    = ON;
          mem_waddr_d = cap_word_addr;
          mem_wdata_d = st_merge;
          rsp_valid_d = ON;
          rsp_tag_d   = tag_q;
          state_d     = RMW_WR;
        end
      end

      RMW_WR: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      kill_q         <= OFF;
      size_q         <= SZ_B;
      uns_q          <= OFF;
      addr_q         <= '0;
      wdata_q        <= WORD_ZERO;
      tag_q          <= '0;
      req_ready_o    <= ON;
      rsp_valid_o    <= OFF;
      rsp_tag_o      <= '0;
      rsp_data_o     <= WORD_ZERO;
      rsp_misalign_o <= OFF;
      mem_we_o       <= OFF;
      mem_waddr_o    <= '0;
      mem_wdata_o    <= WORD_ZERO;
      mem_re_o       <= OFF;
      mem_raddr_o    <= '0;
    end else begin
      state_q        <= state_d;
      kill_q         <= kill_d;
      req_ready_o    <= (state_d == IDLE);
      rsp_valid_o    <= rsp_valid_d;
      rsp_tag_o      <= rsp_tag_d;
      rsp_data_o     <= rsp_data_d;
      rsp_misalign_o <= rsp_mis_d;
      mem_we_o       <= mem_we_d;
      mem_waddr_o    <= mem_waddr_d;
      mem_wdata_o    <= mem_wdata_d;
      mem_re_o       <= mem_re_d;
      mem_raddr_o    <= mem_raddr_d;
      if (cap_en) begin
        size_q  <= req_size_i;
        uns_q   <= req_unsigned_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        tag_q   <= req_tag_i;
      end
    end
  end

endmodule

// File: tb/tb_lsu_l1d_req.sv
// Bench for lsu_l1d_req: a 1-cycle L1D model plus a byte-addressed reference
// memory; directed scenarios followed by randomized requests.
module tb_lsu_l1d_req;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_store_i = 1'b0;
  logic [1:0]  req_size_i = 2'd0;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic [3:0]  req_tag_i = 4'h0;
  logic        flush_i = 1'b0;
  logic        rsp_valid_o;
  logic [3:0]  rsp_tag_o;
  logic [31:0] rsp_data_o;
  logic        rsp_misalign_o;
  logic        mem_we_o;
  logic [31:0] mem_waddr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_re_o;
  logic [31:0] mem_raddr_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;

  always #5 clk = ~clk;

  lsu_l1d_req #(.TAG_W(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_store_i(req_store_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_tag_i(req_tag_i), .flush_i(flush_i),
    .rsp_valid_o(rsp_valid_o), .rsp_tag_o(rsp_tag_o), .rsp_data_o(rsp_data_o),
    .rsp_misalign_o(rsp_misalign_o),
    .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
    .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  // L1D model: read data returns the cycle after mem_re_o
  logic [31:0] l1d [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_a  = 8'h0;
  logic [31:0] pre_d  = 32'h0;

  always @(posedge clk) begin
    mem_rvalid_i <= mem_re_o;
    mem_rdata_i  <= l1d[mem_raddr_o[9:2]];
    if (mem_we_o)    l1d[mem_waddr_o[9:2]] <= mem_wdata_o;
    else if (pre_we) l1d[pre_a] <= pre_d;
  end

  int          n_re = 0, n_we = 0, n_both = 0, n_bad = 0;
  logic [31:0] last_wa = 32'h0, last_wd = 32'h0;

  always @(negedge clk) begin
    if (mem_re_o) n_re++;
    if (mem_we_o) begin
      n_we++;
      last_wa = mem_waddr_o;
      last_wd = mem_wdata_o;
    end
    if (mem_re_o && mem_we_o) n_both++;
    if ((mem_re_o && mem_raddr_o[1:0] != 2'b00) || (mem_we_o && mem_waddr_o[1:0] != 2'b00)) n_bad++;
  end

  logic [7:0] ref_b [0:1023];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  function automatic logic mis_rule(input logic [1:0] sz, input logic [9:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic un, input int a);
    int nb = nbytes(sz);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < nb; k++) v = v | (32'(ref_b[a + k]) << (8 * k));
    if (!un && nb < 4 && v[8 * nb - 1]) v = v - (32'd1 << (8 * nb));
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input int a);
    int w = a - (a % 4);
    return {ref_b[w + 3], ref_b[w + 2], ref_b[w + 1], ref_b[w]};
  endfunction

  logic        r_got, r_mis, r_ready1;
  int          r_lat, d_re, d_we;
  logic [31:0] r_data;
  logic [3:0]  r_tag;

  // fl: 0 none, 1 flush with the request, 2 flush one cycle after acceptance
  task automatic run(input logic st, input logic [1:0] sz, input logic un, input logic [9:0] a,
                     input logic [31:0] wd, input logic [3:0] tg, input int fl);
    int re0, we0, exp_lat, nb;
    logic mis, kill;
    logic [31:0] exp_d;
    re0  = n_re;
    we0  = n_we;
    mis  = mis_rule(sz, a);
    kill = !st && !mis && (fl != 0);
    exp_d = (st || mis) ? 32'h0 : ref_load(sz, un, int'(a));
    exp_lat = (mis || (st && sz == 2'd2)) ? 1 : 3;
    req_valid_i = 1'b1; req_store_i = st; req_size_i = sz; req_unsigned_i = un;
    req_addr_i = {22'h0, a}; req_wdata_i = wd; req_tag_i = tg; flush_i = (fl == 1);
    @(posedge clk); #1;
    req_valid_i = 1'b0; flush_i = 1'b0;
    r_got = 1'b0; r_lat = 0; r_data = 32'h0; r_mis = 1'b0; r_tag = 4'h0;
    r_ready1 = req_ready_o;
    for (int i = 1; i <= 12; i++) begin
      if (i > 1) begin @(posedge clk); #1; end
      if (i == 1 && fl == 2) flush_i = 1'b1;
      if (i == 2) flush_i = 1'b0;
      if (rsp_valid_o && !r_got) begin
        r_got = 1'b1; r_lat = i; r_data = rsp_data_o; r_mis = rsp_misalign_o; r_tag = rsp_tag_o;
      end
    end
    d_re = n_re - re0;
    d_we = n_we - we0;
    chk("rsp_seen", 32'(r_got), 32'(!kill));
    if (!kill) begin
      chk("rsp_latency", r_lat, exp_lat);
      chk("rsp_data", r_data, exp_d);
      chk("rsp_misalign", 32'(r_mis), 32'(mis));
      chk("rsp_tag", 32'(r_tag), 32'(tg));
    end
    chk("read_pulses", d_re, (mis || (st && sz == 2'd2)) ? 0 : 1);
    chk("write_pulses", d_we, (st && !mis) ? 1 : 0);
    chk("ready_after", 32'(req_ready_o), 32'd1);
    if (mis) chk("ready_misalign", 32'(r_ready1), 32'd1);
    if (st && !mis) begin
      nb = nbytes(sz);
      for (int k = 0; k < nb; k++) ref_b[int'(a) + k] = wd[8 * k +: 8];
      chk("write_addr", last_wa, {22'h0, a[9:2], 2'b00});
      chk("write_word", last_wd, ref_word(int'(a)));
    end
  endtask

  initial begin
    logic [31:0] rv;
    int   fl;
    logic [1:0] sz;
    logic [9:0] a;
    logic st;
    int   we0;

    // preload memory while held in reset
    for (int w = 0; w < 256; w++) begin
      rv = $urandom;
      @(negedge clk);
      pre_we = 1'b1; pre_a = 8'(w); pre_d = rv;
      for (int k = 0; k < 4; k++) ref_b[4 * w + k] = rv[8 * k +: 8];
    end
    @(negedge clk);
    pre_we = 1'b0;
    chk("reset_ready", 32'(req_ready_o), 32'd1);
    chk("reset_rsp", {rsp_valid_o, rsp_misalign_o, rsp_tag_o}, 32'h0);
    chk("reset_mem_en", {mem_we_o, mem_re_o}, 32'h0);
    chk("reset_rdata", rsp_data_o, 32'h0);
    chk("reset_addr", mem_waddr_o | mem_raddr_o | mem_wdata_o, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    run(1'b1, 2'd2, 1'b0, 10'h100, 32'hDEADBEEF, 4'd3, 0);
    chk("ws_addr", last_wa, 32'h100);
    chk("ws_data", last_wd, 32'hDEADBEEF);
    chk("ws_tag", 32'(r_tag), 32'd3);
    run(1'b0, 2'd2, 1'b0, 10'h100, 32'h0, 4'd3, 0);
    chk("lw_data", r_data, 32'hDEADBEEF);
    chk("lw_latency", r_lat, 3);

    run(1'b1, 2'd2, 1'b0, 10'h080, 32'h8001F27F, 4'd1, 0);
    run(1'b0, 2'd0, 1'b0, 10'h080, 32'h0, 4'd2, 0);
    chk("lb_80", r_data, 32'h0000007F);
    run(1'b0, 2'd0, 1'b0, 10'h081, 32'h0, 4'd3, 0);
    chk("lb_81", r_data, 32'hFFFFFFF2);
    run(1'b0, 2'd1, 1'b1, 10'h082, 32'h0, 4'd4, 0);
    chk("lhu_82", r_data, 32'h00008001);
    run(1'b0, 2'd1, 1'b0, 10'h082, 32'h0, 4'd5, 0);
    chk("lh_82", r_data, 32'hFFFF8001);

    run(1'b1, 2'd2, 1'b0, 10'h040, 32'h11223344, 4'd6, 0);
    run(1'b1, 2'd0, 1'b0, 10'h042, 32'h000000AA, 4'd7, 0);
    chk("sb_merge", last_wd, 32'h11AA3344);
    chk("sb_reads", d_re, 1);
    run(1'b1, 2'd1, 1'b0, 10'h040, 32'h0000BEEF, 4'd8, 0);
    chk("sh_merge", last_wd, 32'h11AABEEF);

    run(1'b0, 2'd2, 1'b0, 10'h102, 32'h0, 4'd9, 0);
    chk("mis_word", 32'(r_mis), 32'd1);
    run(1'b0, 2'd1, 1'b0, 10'h041, 32'h0, 4'd10, 0);
    chk("mis_half", 32'(r_mis), 32'd1);

    run(1'b0, 2'd2, 1'b0, 10'h100, 32'h0, 4'd5, 2);
    chk("flush_no_rsp", 32'(r_got), 32'd0);
    run(1'b0, 2'd2, 1'b0, 10'h100, 32'h0, 4'd6, 0);
    chk("after_flush_tag", 32'(r_tag), 32'd6);
    chk("after_flush_data", r_data, 32'hDEADBEEF);

    // reset while the RMW read is in flight; its data arrives after release
    we0 = n_we;
    req_valid_i = 1'b1; req_store_i = 1'b1; req_size_i = 2'd0; req_unsigned_i = 1'b0;
    req_addr_i = 32'h41; req_wdata_i = 32'h55; req_tag_i = 4'd11;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(req_ready_o), 32'd1);
    chk("rst_mid_outs", {rsp_valid_o, rsp_misalign_o, mem_we_o, mem_re_o, rsp_tag_o}, 32'h0);
    chk("rst_mid_data", rsp_data_o | mem_wdata_o | mem_waddr_o | mem_raddr_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_rvalid_ignored", {rsp_valid_o, mem_we_o, mem_re_o}, 32'h0);
    chk("rst_release_ready", 32'(req_ready_o), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_write", n_we - we0, 0);
    run(1'b0, 2'd2, 1'b0, 10'h040, 32'h0, 4'd12, 0);
    chk("rst_word_kept", r_data, 32'h11AABEEF);

    for (int n = 0; n < 200; n++) begin
      st = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd2 || sz == 2'd3) a[1:0] = 2'b00;
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd3) sz = 2'd2;
      end
      fl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      if (mis_rule(sz, a)) fl = 0;
      run(st, sz, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), fl);
    end

    chk("never_re_and_we", n_both, 0);
    chk("word_aligned_addr", n_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
